// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_gen,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = $clog2(DIV);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          par;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          bit_end;

  assign full     = fifo_level == LW'(FIFO_DEPTH);
  assign empty    = fifo_level == '0;
  assign tx_ready = !full;
  assign push     = tx_valid && !full;
  assign bit_end  = cnt == '0;
  assign pop      = !empty && (state == IDLE || (state == STOP && bit_end));
  assign busy     = state != IDLE || !empty;

  // byte storage; contents are don't-care while the level says empty
  always_ff @(posedge clk_gen) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // pointers wrap naturally; the level tells full from empty
  always_ff @(posedge clk_gen or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  // frame sequencer; uart_tx is registered from the current state so the line lags the FSM by one cycle
  always_ff @(posedge clk_gen or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par     <= 1'b0;
      uart_tx <= 1'b1;
    end else begin
      uart_tx <= state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par : 1'b1;
      if (pop) begin
        state   <= START;
        shift   <= mem[rd_ptr];
        par     <= ^mem[rd_ptr];
        cnt     <= CW'(DIV - 1);
        bit_idx <= '0;
      end else if (state != IDLE) begin
        cnt <= bit_end ? CW'(DIV - 1) : cnt - 1'b1;
        if (bit_end) begin
          case (state)
            START: state <= DATA;
            DATA: begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7)
`ifdef UART_TX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
            end
            PARITY: state <= STOP;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo at DIV=4, FIFO_DEPTH=4
module tb_uart_tx_fifo;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk_gen = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  logic [7:0] mq[$];
  logic [7:0] eq[$];
  logic [7:0] rx_log[$];
  int         mon_start[$];
  int         m_rem = 0;
  bit         m_pushed = 1'b0;
  logic [7:0] m_cur = 8'h00;

  logic [10:0] mbits;
  bit          mok;
  bit          mab;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] bits;
  } vec_t;
  vec_t vt[6];
  vec_t v3c;

  uart_tx_fifo #(.CLK_FREQ(400), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
    .clk_gen(clk_gen),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .uart_tx(uart_tx),
    .busy(busy),
    .fifo_level(fifo_level)
  );

  initial forever #5 clk_gen = ~clk_gen;

  initial forever begin
    @(posedge clk_gen);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // reference model: a byte queue plus the number of cycles left in the frame on the wire
  initial forever begin
    @(posedge clk_gen or posedge rst);
    if (rst) begin
      mq.delete();
      m_rem = 0;
      m_pushed = 1'b0;
    end else begin
      bit do_push;
      bit do_pop;
      do_push = tx_valid && mq.size() < DEPTH;
      do_pop  = mq.size() > 0 && m_rem <= 1;
      if (m_rem == 1) eq.push_back(m_cur);
      if (do_pop) begin
        m_cur = mq.pop_front();
        m_rem = NB * DIV;
      end else if (m_rem > 0) m_rem--;
      if (do_push) mq.push_back(tx_data);
      m_pushed = do_push;
    end
  end

  // per-cycle comparison of the status outputs against the model
  initial forever begin
    @(negedge clk_gen);
    if (chk_en) begin
      chk("tx_ready", tx_ready, mq.size() < DEPTH);
      chk("fifo_level", fifo_level, mq.size());
      chk("busy", busy, m_rem != 0 || mq.size() != 0);
      if (m_rem == 0) chk("idle_line", uart_tx, 1);
    end
  end

  // line receiver: decodes frames independently of the FSM
  initial forever begin
    @(negedge clk_gen);
    if (chk_en && !rst && uart_tx === 1'b0) begin
      mon_start.push_back(cyc);
      mbits = '0;
      mok = 1'b1;
      mab = 1'b0;
      for (int k = 0; k < NB && !mab; k++)
        for (int c = 0; c < DIV && !mab; c++) begin
          if (k != 0 || c != 0) @(negedge clk_gen);
          if (rst) mab = 1'b1;
          else if (c == 0) mbits[k] = uart_tx;
          else if (uart_tx !== mbits[k]) mok = 1'b0;
        end
      if (mab) void'(mon_start.pop_back());
      else begin
        chk("mon_bits_stable", mok, 1);
        chk("mon_stop_bit", mbits[NB-1], 1);
`ifdef UART_TX_PARITY_EN
        chk("mon_parity", mbits[9], ^mbits[8:1]);
`endif
        rx_log.push_back(mbits[8:1]);
        if (eq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected_frame actual=%0h required=none", mbits[8:1]);
        end else chk("mon_frame_data", mbits[8:1], eq.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((m_rem != 0 || mq.size() != 0) && n < 600) begin
      @(negedge clk_gen);
      n++;
    end
    if (n >= 600) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout actual=busy required=idle");
    end
    repeat (3) @(negedge clk_gen);
  endtask

  task automatic wait_rem1();
    int n = 0;
    while (m_rem != 1 && n < 300) begin
      @(negedge clk_gen);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_frame_end timeout actual=%0d required=1", m_rem);
    end
  endtask

  task automatic send_frame(input vec_t v);
    logic [10:0] got = '0;
    int bad = 0;
    logic b_pre = 1'b0;
    logic b_last = 1'b1;
    string nm = $sformatf("frame_%02h", v.data);
    wait_idle();
    @(negedge clk_gen);
    tx_data = v.data;
    tx_valid = 1'b1;
    @(negedge clk_gen);
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    @(negedge clk_gen);
    chk({nm, "_latency"}, uart_tx, 1);
    for (int j = 0; j < NB * DIV; j++) begin
      @(negedge clk_gen);
      if (j % DIV == 0) got[j/DIV] = uart_tx;
      else if (uart_tx !== got[j/DIV]) bad++;
      if (j == NB * DIV - 2) b_pre = busy;
      if (j == NB * DIV - 1) b_last = busy;
    end
    chk(nm, got, v.bits);
    chk({nm, "_bit_len"}, bad, 0);
    chk({nm, "_busy_in_stop"}, b_pre, 1);
    chk({nm, "_busy_after"}, b_last, 0);
    @(negedge clk_gen);
    chk({nm, "_idle"}, uart_tx, 1);
  endtask

  initial begin
    int k;
    int maxl;
`ifdef UART_TX_PARITY_EN
    vt[0] = '{8'h55, 11'b1_0_01010101_0};
    vt[1] = '{8'h07, 11'b1_1_00000111_0};
    vt[2] = '{8'h03, 11'b1_0_00000011_0};
    vt[3] = '{8'h00, 11'b1_0_00000000_0};
    vt[4] = '{8'hFF, 11'b1_0_11111111_0};
    vt[5] = '{8'h80, 11'b1_1_10000000_0};
    v3c   = '{8'h3C, 11'b1_0_00111100_0};
`else
    vt[0] = '{8'h55, 11'b0_1_01010101_0};
    vt[1] = '{8'h07, 11'b0_1_00000111_0};
    vt[2] = '{8'h03, 11'b0_1_00000011_0};
    vt[3] = '{8'h00, 11'b0_1_00000000_0};
    vt[4] = '{8'hFF, 11'b0_1_11111111_0};
    vt[5] = '{8'h80, 11'b0_1_10000000_0};
    v3c   = '{8'h3C, 11'b0_1_00111100_0};
`endif
    #1 rst = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_gen);
      tx_valid = i[0];
      tx_data = 8'($urandom);
      chk("rst_uart_tx", uart_tx, 1);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_level", fifo_level, 0);
    end
    @(negedge clk_gen);
    tx_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk_gen);
    chk("post_rst_level", fifo_level, 0);
    chk("post_rst_busy", busy, 0);

    for (int i = 0; i < 6; i++) send_frame(vt[i]);

    wait_idle();
    @(negedge clk_gen);
    tx_data = 8'hA3;
    tx_valid = 1'b1;
    @(negedge clk_gen);
    tx_valid = 1'b0;
    @(negedge clk_gen);
    repeat (4 * DIV + 2) @(negedge clk_gen);
    chk("abort_pre_line", uart_tx, 0);
    #1 rst = 1'b1;
    #1;
    chk("abort_line", uart_tx, 1);
    chk("abort_level", fifo_level, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", tx_ready, 1);
    @(negedge clk_gen);
    @(negedge clk_gen);
    rst = 1'b0;
    send_frame(v3c);

    wait_idle();
    rx_log.delete();
    mon_start.delete();
    maxl = 0;
    k = 1;
    tx_data = 8'h01;
    tx_valid = 1'b1;
    for (int n = 0; n < 400 && k <= 5; n++) begin
      @(negedge clk_gen);
      if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
      if (m_pushed) begin
        k++;
        tx_data = 8'(k);
      end
    end
    tx_valid = 1'b0;
    chk("burst_accepted", k, 6);
    chk("burst_max_level", maxl, 4);
    wait_idle();
    chk("burst_frames", rx_log.size(), 5);
    if (rx_log.size() == 5)
      for (int i = 0; i < 5; i++) chk("burst_order", rx_log[i], i + 1);
    if (mon_start.size() == 5)
      for (int i = 1; i < 5; i++) chk("burst_gap", mon_start[i] - mon_start[i-1], NB * DIV);

    wait_idle();
    @(negedge clk_gen);
    tx_valid = 1'b1;
    tx_data = 8'h11;
    @(negedge clk_gen);
    tx_data = 8'h22;
    @(negedge clk_gen);
    tx_data = 8'h33;
    @(negedge clk_gen);
    tx_valid = 1'b0;
    chk("pp_level_before", fifo_level, 2);
    wait_rem1();
    tx_valid = 1'b1;
    tx_data = 8'h44;
    @(negedge clk_gen);
    chk("pp_level_same", fifo_level, 2);
    tx_data = 8'h55;
    @(negedge clk_gen);
    tx_data = 8'h66;
    @(negedge clk_gen);
    tx_data = 8'h77;
    chk("full_level", fifo_level, 4);
    chk("full_ready", tx_ready, 0);
    repeat (3) begin
      @(negedge clk_gen);
      chk("full_hold_ready", tx_ready, 0);
      chk("full_hold_level", fifo_level, 4);
    end
    wait_rem1();
    @(negedge clk_gen);
    chk("full_no_bypass_level", fifo_level, 3);
    chk("full_no_bypass_ready", tx_ready, 1);
    @(negedge clk_gen);
    tx_valid = 1'b0;
    chk("full_refill_level", fifo_level, 4);
    wait_idle();

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_gen);
      tx_valid = $urandom_range(0, 99) < (((n / 500) % 2 == 1) ? 60 : 3);
      tx_data = 8'($urandom);
    end
    @(negedge clk_gen);
    tx_valid = 1'b0;
    wait_idle();
    chk("all_frames_seen", eq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
